// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Brings a PLLE2_BASE up and keeps it up. The block drives the PLL RST and
// PWRDWN pins and watches LOCKED. It holds the downstream fabric reset
// (sys_reset_n) asserted until lock has been seen continuously for
// STABLE_CYCLES cycles. A lock timeout or a lock drop before release counts
// as a failed attempt, and the PLL is reset again. Once retry_count has
// reached MAX_RETRIES, the next failure parks the block in FAULT.
//
// Ports:
//   clk             board clock, free-running (also feeds PLL CLKIN1)
//   reset_n         synchronous, active-low reset
//   enable          1 = bring PLL up, 0 = power PLL down
//   pll_locked      PLL LOCKED, asynchronous to clk
//   pll_rst         to PLL RST
//   pll_pwrdwn      to PLL PWRDWN
//   sys_reset_n     active-low reset for the PLL clock domains
//   locked_stable   same value as sys_reset_n
//   fault           sticky, set once retries are exhausted
//   retry_count     failed attempts since the last successful lock (saturating)
//   lock_loss_count lock losses seen in RUN (saturating at 255)
//   state           FSM state: POWERDOWN=0 RESET=1 WAIT_LOCK=2 STABLE=3
//                   RUN=4 FAULT=5
//
// All outputs come straight from flops. No valid/ready handshakes exist
// here. enable and pll_locked are level inputs, and every output is a level.

module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,    // must exceed SYNC_STAGES
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,     // 1..15
  parameter int SYNC_STAGES   = 2      // >= 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       sys_reset_n,
  output logic       locked_stable,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_POWERDOWN = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // The counter is wide enough for the longest of the three timed phases.
  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t                 state_q;
  logic [CNT_W-1:0]       counter;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   attempt_failed;

  assign locked_s      = sync_q[SYNC_STAGES-1];
  assign state         = state_q;
  assign locked_stable = sys_reset_n;

  // Metastability chain for the asynchronous LOCKED pin. The FSM reads only
  // the last stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // An attempt fails on a lock timeout in WAIT_LOCK, or on any sampled low
  // lock in STABLE. The STABLE case wins even on the final counted cycle.
  always_comb begin
    attempt_failed = 1'b0;
    if (state_q == ST_WAIT_LOCK && !locked_s && counter == TIMEOUT_LAST) begin
      attempt_failed = 1'b1;
    end
    if (state_q == ST_STABLE && !locked_s) begin
      attempt_failed = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_RESET;
      counter         <= '0;
      pll_rst         <= 1'b1;
      pll_pwrdwn      <= 1'b0;
      sys_reset_n     <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else if (!enable) begin
      // Power-down clears the retry history and any fault. The lock-loss
      // statistics survive.
      state_q     <= ST_POWERDOWN;
      counter     <= '0;
      pll_rst     <= 1'b1;
      pll_pwrdwn  <= 1'b1;
      sys_reset_n <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
    end else if (attempt_failed) begin
      counter     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      if (retry_count == RETRY_LIMIT) begin
        state_q <= ST_FAULT;
        fault   <= 1'b1;
      end else begin
        state_q <= ST_RESET;
        if (retry_count != 4'hF) begin
          retry_count <= retry_count + 4'd1;
        end
      end
    end else begin
      case (state_q)
        ST_POWERDOWN: begin
          state_q     <= ST_RESET;
          counter     <= '0;
          pll_rst     <= 1'b1;
          pll_pwrdwn  <= 1'b0;
          sys_reset_n <= 1'b0;
        end
        ST_RESET: begin
          pll_rst    <= 1'b1;
          pll_pwrdwn <= 1'b0;
          if (counter == RST_LAST) begin
            state_q <= ST_WAIT_LOCK;
            counter <= '0;
            pll_rst <= 1'b0;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_STABLE;
            counter <= '0;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // Reaching this branch means locked_s is high.
          if (counter == STABLE_LAST) begin
            state_q     <= ST_RUN;
            counter     <= '0;
            sys_reset_n <= 1'b1;
            retry_count <= '0;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        ST_RUN: begin
          // A lost lock starts a fresh reset attempt. It does not count
          // against the retry budget.
          if (!locked_s) begin
            state_q     <= ST_RESET;
            counter     <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          state_q     <= ST_RESET;
          counter     <= '0;
          pll_rst     <= 1'b1;
          pll_pwrdwn  <= 1'b0;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer. It uses RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2 and SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       sys_reset_n;
  logic       locked_stable;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Control snapshot: {state, pll_rst, pll_pwrdwn, sys_reset_n, locked_stable, fault}
  logic [7:0] ctl;
  assign ctl = {state, pll_rst, pll_pwrdwn, sys_reset_n, locked_stable, fault};

  localparam logic [7:0] CTL_PD     = {3'd0, 5'b11000};
  localparam logic [7:0] CTL_RST    = {3'd1, 5'b10000};
  localparam logic [7:0] CTL_WAIT   = {3'd2, 5'b00000};
  localparam logic [7:0] CTL_STABLE = {3'd3, 5'b00000};
  localparam logic [7:0] CTL_RUN    = {3'd4, 5'b00110};
  localparam logic [7:0] CTL_FAULT  = {3'd5, 5'b10001};

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .SYNC_STAGES  (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .pll_pwrdwn     (pll_pwrdwn),
    .sys_reset_n    (sys_reset_n),
    .locked_stable  (locked_stable),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    enable     = 1'b1;
    pll_locked = 1'b0;
    ticks(2);
    reset_n = 1'b1;
  endtask

  // From a just-released reset: 4 cycles of RESET, then lock, then 11 cycles to RUN
  task automatic bring_up();
    ticks(4);
    pll_locked = 1'b1;
    ticks(11);
  endtask

  // From RUN: lose lock, sit out the reset pulse, relock and return to RUN
  task automatic lose_and_relock();
    pll_locked = 1'b0;
    ticks(3);
    ticks(4);
    pll_locked = 1'b1;
    ticks(11);
  endtask

  // Test scenarios
  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;  // reset_n must win over enable=0
    pll_locked = 1'b0;
    ticks(2);
    checks++;
    if (ctl !== CTL_RST) begin
      errors++;
      $display("FAIL reset_ctl: got %h expected %h", ctl, CTL_RST);
    end
    checks++;
    if (retry_count !== 4'd0 || lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: got retry=%0d loss=%0d expected 0 0", retry_count, lock_loss_count);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_bring_up();
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ctl !== CTL_RST) begin
        errors++;
        $display("FAIL bringup_rst_hold[%0d]: got %h expected %h", i, ctl, CTL_RST);
      end
    end
    tick();
    checks++;
    if (ctl !== CTL_WAIT) begin
      errors++;
      $display("FAIL bringup_rst_release: got %h expected %h", ctl, CTL_WAIT);
    end
    ticks(6);
    pll_locked = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (sys_reset_n !== 1'b0) begin
        errors++;
        $display("FAIL bringup_early_release[%0d]: got %b expected 0", i, sys_reset_n);
      end
    end
    checks++;
    if (ctl !== CTL_STABLE) begin
      errors++;
      $display("FAIL bringup_stable: got %h expected %h", ctl, CTL_STABLE);
    end
    tick();
    checks++;
    if (ctl !== CTL_RUN || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL bringup_run: got ctl=%h retry=%0d expected ctl=%h retry=0", ctl, retry_count, CTL_RUN);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (ctl !== CTL_RUN) begin
        errors++;
        $display("FAIL loss_early[%0d]: got %h expected %h", i, ctl, CTL_RUN);
      end
    end
    tick();
    checks++;
    if (ctl !== CTL_RST || lock_loss_count !== 8'd1 || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL loss_drop: got ctl=%h loss=%0d retry=%0d expected ctl=%h loss=1 retry=0",
               ctl, lock_loss_count, retry_count, CTL_RST);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pll_rst !== 1'b1) begin
        errors++;
        $display("FAIL loss_rst_pulse[%0d]: got %b expected 1", i, pll_rst);
      end
    end
    tick();
    checks++;
    if (ctl !== CTL_WAIT) begin
      errors++;
      $display("FAIL loss_rst_end: got %h expected %h", ctl, CTL_WAIT);
    end
    pll_locked = 1'b1;
    ticks(11);
    checks++;
    if (ctl !== CTL_RUN || lock_loss_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_relock: got ctl=%h loss=%0d expected ctl=%h loss=1", ctl, lock_loss_count, CTL_RUN);
    end
  endtask

  task automatic test_stability_glitch();
    apply_reset();
    ticks(4);
    pll_locked = 1'b1;
    ticks(3);
    checks++;
    if (ctl !== CTL_STABLE) begin
      errors++;
      $display("FAIL glitch_enter_stable: got %h expected %h", ctl, CTL_STABLE);
    end
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++;
    if (ctl !== CTL_STABLE) begin
      errors++;
      $display("FAIL glitch_in_sync: got %h expected %h", ctl, CTL_STABLE);
    end
    tick();
    checks++;
    if (ctl !== CTL_RST || retry_count !== 4'd1) begin
      errors++;
      $display("FAIL glitch_fail: got ctl=%h retry=%0d expected ctl=%h retry=1", ctl, retry_count, CTL_RST);
    end
    pll_locked = 1'b0;
    ticks(4);
    checks++;
    if (ctl !== CTL_WAIT) begin
      errors++;
      $display("FAIL glitch_retry_wait: got %h expected %h", ctl, CTL_WAIT);
    end
    pll_locked = 1'b1;
    ticks(11);
    checks++;
    if (ctl !== CTL_RUN || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL glitch_relock: got ctl=%h retry=%0d expected ctl=%h retry=0", ctl, retry_count, CTL_RUN);
    end
  endtask

  task automatic test_never_lock();
    apply_reset();
    ticks(4);
    for (int k = 1; k <= 2; k++) begin
      ticks(31);
      checks++;
      if (ctl !== CTL_WAIT) begin
        errors++;
        $display("FAIL nolock_before_timeout[%0d]: got %h expected %h", k, ctl, CTL_WAIT);
      end
      tick();
      checks++;
      if (ctl !== CTL_RST || retry_count !== 4'(k)) begin
        errors++;
        $display("FAIL nolock_timeout[%0d]: got ctl=%h retry=%0d expected ctl=%h retry=%0d",
                 k, ctl, retry_count, CTL_RST, k);
      end
      ticks(4);
    end
    ticks(31);
    checks++;
    if (ctl !== CTL_WAIT) begin
      errors++;
      $display("FAIL nolock_last_wait: got %h expected %h", ctl, CTL_WAIT);
    end
    tick();
    checks++;
    if (ctl !== CTL_FAULT || retry_count !== 4'd2) begin
      errors++;
      $display("FAIL nolock_fault: got ctl=%h retry=%0d expected ctl=%h retry=2", ctl, retry_count, CTL_FAULT);
    end
    pll_locked = 1'b1;
    ticks(10);
    checks++;
    if (ctl !== CTL_FAULT) begin
      errors++;
      $display("FAIL nolock_fault_sticky: got %h expected %h", ctl, CTL_FAULT);
    end
  endtask

  task automatic test_enable();
    // Starts in FAULT
    pll_locked = 1'b0;
    enable     = 1'b0;
    tick();
    checks++;
    if (ctl !== CTL_PD || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL enable_fault_clear: got ctl=%h retry=%0d expected ctl=%h retry=0", ctl, retry_count, CTL_PD);
    end
    enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      checks++;
      if (ctl !== CTL_RST) begin
        errors++;
        $display("FAIL enable_restart[%0d]: got %h expected %h", pass, ctl, CTL_RST);
      end
      for (int i = 1; i <= 3; i++) begin
        tick();
        checks++;
        if (pll_rst !== 1'b1) begin
          errors++;
          $display("FAIL enable_rst_hold[%0d.%0d]: got %b expected 1", pass, i, pll_rst);
        end
      end
      tick();
      checks++;
      if (ctl !== CTL_WAIT) begin
        errors++;
        $display("FAIL enable_wait[%0d]: got %h expected %h", pass, ctl, CTL_WAIT);
      end
      if (pass == 0) begin
        ticks(5);
        enable = 1'b0;
        tick();
        checks++;
        if (ctl !== CTL_PD) begin
          errors++;
          $display("FAIL enable_low_in_wait: got %h expected %h", ctl, CTL_PD);
        end
        enable = 1'b1;
      end
    end
  endtask

  task automatic test_reset_in_run();
    apply_reset();
    bring_up();
    for (int i = 0; i < 3; i++) lose_and_relock();
    checks++;
    if (ctl !== CTL_RUN || lock_loss_count !== 8'd3) begin
      errors++;
      $display("FAIL rstrun_setup: got ctl=%h loss=%0d expected ctl=%h loss=3", ctl, lock_loss_count, CTL_RUN);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (ctl !== CTL_RST || lock_loss_count !== 8'd0 || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL rstrun_reset: got ctl=%h loss=%0d retry=%0d expected ctl=%h loss=0 retry=0",
               ctl, lock_loss_count, retry_count, CTL_RST);
    end
  endtask

  task automatic test_loss_saturation();
    apply_reset();
    bring_up();
    for (int i = 0; i < 255; i++) lose_and_relock();
    checks++;
    if (ctl !== CTL_RUN || lock_loss_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_reach: got ctl=%h loss=%0d expected ctl=%h loss=255", ctl, lock_loss_count, CTL_RUN);
    end
    lose_and_relock();
    checks++;
    if (ctl !== CTL_RUN || lock_loss_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: got ctl=%h loss=%0d expected ctl=%h loss=255", ctl, lock_loss_count, CTL_RUN);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_bring_up();
    test_lock_loss();
    test_stability_glitch();
    test_never_lock();
    test_enable();
    test_reset_in_run();
    test_loss_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
